// File: rtl/data_unloader.sv
// Bridge read unloader: assembles 32-bit words from a byte-wide memory and
// prefetches the next sequential word so that streaming reads hit in one cycle.
module data_unloader #(
    parameter int ADDRESS_SIZE         = 15,
    parameter int READ_MEM_CLOCK_DELAY = 1
) (
    input  logic                    clk_74a,
    input  logic                    reset,
    input  logic                    bridge_rd,
    input  logic                    bridge_endian_little,
    input  logic [31:0]             bridge_addr,
    output logic [31:0]             bridge_rd_data,
    output logic                    rd_data_valid,
    output logic                    read_en,
    output logic [ADDRESS_SIZE-1:0] read_addr,
    input  logic [7:0]              read_data
);

    localparam int WAIT_LAST = (READ_MEM_CLOCK_DELAY >= 2) ? READ_MEM_CLOCK_DELAY - 2 : 0;
    localparam int CW        = (READ_MEM_CLOCK_DELAY > 2) ? $clog2(READ_MEM_CLOCK_DELAY - 1) : 1;
    localparam int WW        = ADDRESS_SIZE - 2;
    localparam logic [WW-1:0] WORD_ONE = 1;
    localparam logic [CW-1:0] CNT_LAST = WAIT_LAST;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    state_t          state;
    logic [1:0]      k;
    logic [CW-1:0]   wait_cnt;
    logic            demand;
    logic [WW-1:0]   fetch_word;
    logic            fetch_le;
    logic [WW-1:0]   req_word;
    logic            req_le;
    logic [31:0]     word_buf;
    logic [31:0]     pf_word;
    logic [WW-1:0]   pf_addr;
    logic            pf_le;
    logic            pf_valid;

    logic [WW-1:0]   rd_word;
    logic [31:0]     cap_word;
    logic            last_byte;
    logic            buf_hit;
    logic            fly_hit;
    logic            unused_addr_bits;

    always_comb begin
        rd_word          = bridge_addr[ADDRESS_SIZE-1:2];
        unused_addr_bits = ^{bridge_addr[31:ADDRESS_SIZE], bridge_addr[1:0]};
        cap_word         = word_buf;
        if (fetch_le)
            cap_word[{k, 3'b000} +: 8] = read_data;
        else
            cap_word[{~k, 3'b000} +: 8] = read_data;
        last_byte = (state == CAPTURE) && (k == 2'd3);
        buf_hit   = pf_valid && (pf_addr == rd_word) && (pf_le == bridge_endian_little);
        // A prefetch finishing in this very cycle can satisfy the request directly.
        fly_hit   = last_byte && !demand && (fetch_word == rd_word)
                    && (fetch_le == bridge_endian_little);
    end

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            state          <= IDLE;
            k              <= '0;
            wait_cnt       <= '0;
            demand         <= 1'b0;
            fetch_word     <= '0;
            fetch_le       <= 1'b0;
            req_word       <= '0;
            req_le         <= 1'b0;
            word_buf       <= '0;
            pf_word        <= '0;
            pf_addr        <= '0;
            pf_le          <= 1'b0;
            pf_valid       <= 1'b0;
            bridge_rd_data <= '0;
            rd_data_valid  <= 1'b0;
            read_en        <= 1'b0;
            read_addr      <= '0;
        end else begin
            rd_data_valid <= 1'b0;
            read_en       <= 1'b0;
            if (bridge_rd) begin
                req_word <= rd_word;
                req_le   <= bridge_endian_little;
                if (fly_hit || buf_hit) begin
                    bridge_rd_data <= fly_hit ? cap_word : pf_word;
                    rd_data_valid  <= 1'b1;
                    state          <= DONE;
                    if (fly_hit) begin
                        pf_word  <= cap_word;
                        pf_addr  <= fetch_word;
                        pf_le    <= fetch_le;
                        pf_valid <= 1'b1;
                    end
                end else begin
                    pf_valid   <= 1'b0;
                    demand     <= 1'b1;
                    fetch_word <= rd_word;
                    fetch_le   <= bridge_endian_little;
                    k          <= 2'd0;
                    read_en    <= 1'b1;
                    read_addr  <= {rd_word, 2'b00};
                    state      <= ISSUE;
                end
            end else begin
                case (state)
                    IDLE: ;
                    DONE: begin
                        demand     <= 1'b0;
                        fetch_word <= req_word + WORD_ONE;
                        fetch_le   <= req_le;
                        k          <= 2'd0;
                        read_en    <= 1'b1;
                        read_addr  <= {req_word + WORD_ONE, 2'b00};
                        state      <= ISSUE;
                    end
                    ISSUE: begin
                        wait_cnt <= '0;
                        if (READ_MEM_CLOCK_DELAY == 1)
                            state <= CAPTURE;
                        else
                            state <= WAIT;
                    end
                    WAIT: begin
                        if (wait_cnt == CNT_LAST)
                            state <= CAPTURE;
                        else
                            wait_cnt <= wait_cnt + 1'b1;
                    end
                    CAPTURE: begin
                        word_buf <= cap_word;
                        if (k != 2'd3) begin
                            k         <= k + 2'd1;
                            read_en   <= 1'b1;
                            read_addr <= {fetch_word, k + 2'd1};
                            state     <= ISSUE;
                        end else if (demand) begin
                            bridge_rd_data <= cap_word;
                            rd_data_valid  <= 1'b1;
                            state          <= DONE;
                        end else begin
                            pf_word  <= cap_word;
                            pf_addr  <= fetch_word;
                            pf_le    <= fetch_le;
                            pf_valid <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_unloader.sv
// Directed bench for data_unloader: memory returns the low address byte one cycle after read_en.
module tb_data_unloader;

    logic        clk = 1'b0;
    logic        reset;
    logic        bridge_rd;
    logic        bridge_endian_little;
    logic [31:0] bridge_addr;
    logic [31:0] bridge_rd_data;
    logic        rd_data_valid;
    logic        read_en;
    logic [14:0] read_addr;
    logic [7:0]  read_data = 8'h00;

    int checks = 0;
    int errors = 0;

    logic        t_en   [0:63];
    logic [14:0] t_addr [0:63];
    logic        t_val  [0:63];
    logic [31:0] t_data [0:63];

    data_unloader #(
        .ADDRESS_SIZE(15),
        .READ_MEM_CLOCK_DELAY(1)
    ) dut (
        .clk_74a(clk),
        .reset(reset),
        .bridge_rd(bridge_rd),
        .bridge_endian_little(bridge_endian_little),
        .bridge_addr(bridge_addr),
        .bridge_rd_data(bridge_rd_data),
        .rd_data_valid(rd_data_valid),
        .read_en(read_en),
        .read_addr(read_addr),
        .read_data(read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (read_en) read_data <= read_addr[7:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the current (negedge) cycle carrying bridge_rd; cycles 1..n are recorded.
    task automatic run(input logic [31:0] a, input logic le, input int n,
                       input int inj, input logic [31:0] inj_a, input int rst_at);
        bridge_rd            = 1'b1;
        bridge_addr          = a;
        bridge_endian_little = le;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            t_en[c]   = read_en;
            t_addr[c] = read_addr;
            t_val[c]  = rd_data_valid;
            t_data[c] = bridge_rd_data;
            bridge_rd = (c == inj);
            if (c == inj) bridge_addr = inj_a;
            reset = (c == rst_at);
        end
        bridge_rd = 1'b0;
        reset     = 1'b0;
    endtask

    function automatic int count_valid(input int n);
        int s = 0;
        for (int c = 1; c <= n; c++) if (t_val[c]) s++;
        return s;
    endfunction

    function automatic int first_valid(input int n);
        for (int c = 1; c <= n; c++) if (t_val[c]) return c;
        return 0;
    endfunction

    function automatic int count_en(input int lo, input int hi);
        int s = 0;
        for (int c = lo; c <= hi; c++) if (t_en[c]) s++;
        return s;
    endfunction

    task automatic check_miss(input string tag, input logic [14:0] base, input logic [31:0] exp);
        for (int b = 0; b < 4; b++) begin
            check({tag, "_en"}, 32'(t_en[1 + 2*b]), 32'd1);
            check({tag, "_addr"}, 32'(t_addr[1 + 2*b]), 32'(base + 15'(b)));
        end
        check({tag, "_en_cnt"}, 32'(count_en(1, 8)), 32'd4);
        check({tag, "_vcyc"}, 32'(first_valid(20)), 32'd9);
        check({tag, "_data"}, t_data[9], exp);
    endtask

    task automatic check_pf(input string tag, input int s, input logic [14:0] base);
        for (int b = 0; b < 4; b++) begin
            check({tag, "_en"}, 32'(t_en[s + 2*b]), 32'd1);
            check({tag, "_addr"}, 32'(t_addr[s + 2*b]), 32'(base + 15'(b)));
        end
    endtask

    initial begin
        reset = 1'b1;
        bridge_rd = 1'b0;
        bridge_addr = '0;
        bridge_endian_little = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", bridge_rd_data, 32'h0);
        check("rst_valid", 32'(rd_data_valid), 32'd0);
        check("rst_en", 32'(read_en), 32'd0);
        check("rst_addr", 32'(read_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Miss at 0x0C, then background prefetch of 0x10
        run(32'h0C, 1'b0, 20, 0, 0, 0);
        check_miss("a", 15'h0C, 32'h0C0D0E0F);
        check("a_vcnt", 32'(count_valid(20)), 32'd1);
        check_pf("a_pf", 10, 15'h10);

        // Hit at 0x10, reset during the following prefetch
        run(32'h10, 1'b0, 12, 0, 0, 4);
        check("c_vcyc", 32'(first_valid(12)), 32'd1);
        check("c_data", t_data[1], 32'h10111213);
        check("c_en1", 32'(t_en[1]), 32'd0);
        check("c_pf_en", 32'(t_en[2]), 32'd1);
        check("c_pf_addr", 32'(t_addr[2]), 32'h14);
        check("c_rst_data", t_data[5], 32'h0);
        check("c_rst_addr", 32'(t_addr[5]), 32'h0);
        check("c_vcnt", 32'(count_valid(12)), 32'd1);
        check("c_rst_en", 32'(count_en(5, 12)), 32'd0);

        // Prefetch was invalidated by reset: 0x10 must miss
        run(32'h10, 1'b0, 20, 0, 0, 0);
        check_miss("d", 15'h10, 32'h10111213);

        run(32'h14, 1'b0, 12, 0, 0, 0);
        check("e_vcyc", 32'(first_valid(12)), 32'd1);
        check("e_data", t_data[1], 32'h14151617);
        check("e_en1", 32'(t_en[1]), 32'd0);
        check("e_pf_addr", 32'(t_addr[2]), 32'h18);
        check("e_vcnt", 32'(count_valid(12)), 32'd1);

        // Little-endian, aligned and unaligned request addresses
        run(32'h20, 1'b1, 20, 0, 0, 0);
        check_miss("f", 15'h20, 32'h23222120);
        run(32'h23, 1'b1, 20, 0, 0, 0);
        check("g_vcyc", 32'(first_valid(20)), 32'd9);
        check("g_data", t_data[9], 32'h23222120);

        // Address wrap, then hit with ignored upper address bit
        run(32'h7FFC, 1'b0, 20, 0, 0, 0);
        check_miss("h", 15'h7FFC, 32'hFCFDFEFF);
        check_pf("h_pf", 10, 15'h0000);
        run(32'h8000, 1'b0, 12, 0, 0, 0);
        check("i_vcyc", 32'(first_valid(12)), 32'd1);
        check("i_data", t_data[1], 32'h00010203);
        check("i_en1", 32'(t_en[1]), 32'd0);

        // Endianness mismatch with a valid prefetch at the same address misses
        run(32'h04, 1'b1, 20, 0, 0, 0);
        check("j_vcyc", 32'(first_valid(20)), 32'd9);
        check("j_data", t_data[9], 32'h07060504);

        // Abort: second request three cycles into the first
        run(32'h20, 1'b0, 26, 3, 32'h40, 0);
        check("k_vcnt", 32'(count_valid(26)), 32'd1);
        check("k_vcyc", 32'(first_valid(26)), 32'd12);
        check("k_data", t_data[12], 32'h40414243);
        check("k_en4", 32'(t_en[4]), 32'd1);
        check("k_addr4", 32'(t_addr[4]), 32'h40);

        // Request in the same cycle the prefetch of 0x4C captures its last byte
        run(32'h48, 1'b0, 24, 17, 32'h4C, 0);
        check("l_vcnt", 32'(count_valid(24)), 32'd2);
        check("l_v9", 32'(t_val[9]), 32'd1);
        check("l_d9", t_data[9], 32'h48494A4B);
        check("l_v18", 32'(t_val[18]), 32'd1);
        check("l_d18", t_data[18], 32'h4C4D4E4F);
        check("l_en18", 32'(t_en[18]), 32'd0);
        check("l_en19", 32'(t_en[19]), 32'd1);
        check("l_addr19", 32'(t_addr[19]), 32'h50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_unloader.md
Name: data_unloader

Overview:
- Read-side counterpart to the bridge data loader.
- Services APF bridge reads by fetching 4 bytes from a byte-wide core memory and assembling a 32-bit word onto bridge_rd_data.
- Single clock domain (clk_74a). The memory read port is driven on this clock.
- After every completed word, prefetches the next sequential word so that sequential bridge reads return in one cycle.

Parameters:
- ADDRESS_SIZE, 15: width of the memory byte address; bridge_addr[ADDRESS_SIZE-1:0] is used and upper bits are ignored.
- READ_MEM_CLOCK_DELAY, 1: cycles from a read_en cycle to the cycle where read_data is valid. Must be ≥1.

Ports:
- clk_74a  in  1  bridge/system clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- bridge_rd  in  1  one-cycle read request strobe.
- bridge_endian_little  in  1  1 = little-endian byte packing, sampled with bridge_rd.
- bridge_addr  in  32  byte address of the request; bits [1:0] are ignored (word aligned).
- bridge_rd_data  out  32  assembled word; holds until the next word completes.
- rd_data_valid  out  1  one-cycle pulse when bridge_rd_data updates for a request.
- read_en  out  1  one-cycle memory read strobe.
- read_addr  out  ADDRESS_SIZE  memory byte address.
- read_data  in  8  memory byte, valid READ_MEM_CLOCK_DELAY cycles after read_en.

Behaviour:
- Reset: synchronous, active-high. Outputs go to bridge_rd_data=0, rd_data_valid=0, read_en=0, read_addr=0. State becomes IDLE, the prefetch buffer is invalidated, and any fetch in progress is dropped.
- Word base: W = {bridge_addr[ADDRESS_SIZE-1:2], 2'b00}.
- Byte packing:
  - Big-endian: byte at W+k goes to bits [31-8k -: 8].
  - Little-endian: byte at W+k goes to bits [8k+7 -: 8].
  - Endianness is latched at the request. A prefetch uses the endianness of the last request.
- States:
  - IDLE
  - ISSUE: read_en=1, read_addr=base+k.
  - WAIT: count READ_MEM_CLOCK_DELAY-1 cycles.
  - CAPTURE: store read_data into byte k. If k<3, go to ISSUE with k+1; otherwise go to DONE.
  - DONE
  - D = READ_MEM_CLOCK_DELAY. With D=1, WAIT is skipped and the byte is captured D cycles after ISSUE.
- Byte timing: byte k is issued at cycle 1+k(D+1) and captured at 1+k(D+1)+D.
- Miss (bridge_rd at cycle 0 and no prefetch hit):
  - Demand fetch of W starts at cycle 1.
  - bridge_rd_data updates and rd_data_valid pulses at cycle 5+4D (cycle 9 for D=1).
- Hit (prefetch valid, prefetch address == W, endianness matches):
  - bridge_rd_data = prefetch word and rd_data_valid=1 at cycle 1.
  - No memory reads are made for this request.
- Prefetch:
  - In the cycle after any word is delivered (hit or miss), a background fetch of W+4 starts, wrapping modulo 2^ADDRESS_SIZE.
  - On completion it loads the prefetch buffer, sets prefetch valid, and does not pulse rd_data_valid.
- bridge_rd while a fetch (demand or prefetch) is in progress: abort immediately. Read data still in flight is discarded. Prefetch is invalidated unless the request is a hit on an already-valid buffer. The new request is then serviced with miss/hit timing measured from this bridge_rd. Only one rd_data_valid pulse is produced, for the newest request.
- bridge_rd in the same cycle as a prefetch completion at the same address: treated as a hit using the just-completed word, with data at cycle 1.
- read_en is never high for more than 1 consecutive cycle. Memory reads are never issued while IDLE.

Test Plan:
- Memory model is mem[a]=a[7:0], D=1. bridge_rd, addr 0x0C, big-endian → read_en at cycles 1,3,5,7 with read_addr 0xC,0xD,0xE,0xF; bridge_rd_data=0x0C0D0E0F and rd_data_valid pulse at cycle 9; prefetch reads 0x10–0x13 follow.
- After prefetch completes: bridge_rd at 0x10 → 0x10111213 valid at cycle 1, no read_en during the request cycle; a new prefetch of 0x14 follows.
- Little-endian, addr 0x20 → 0x23222120 at cycle 9; bits [1:0]=3 (addr 0x23) give the same result.
- Wrap: addr 0x7FFC, big-endian → 0xFCFDFEFF; prefetch read_addr sequence is 0x0000..0x0003; bridge_rd at 0x8000 (upper bit ignored) hits and returns 0x00010203.
- Abort: bridge_rd at 0x20, then bridge_rd at 0x40 three cycles later → exactly one rd_data_valid, with data 0x40414243, 9 cycles after the second request.
- Reset asserted mid-fetch for 1 cycle → outputs 0, no rd_data_valid, no further read_en; the next bridge_rd at 0x10 is a miss (9 cycles), proving the prefetch was invalidated.
